// File: rtl/tick_gen.sv
// Programmable timebase: divides clk by a runtime divisor, producing a one-cycle
// tick, a 50% square wave and a cascaded second-stage tick2 every DIV2 ticks.
module tick_gen #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 100,
    parameter int unsigned DIV2        = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             sq,
    output logic             tick2,
    output logic [WIDTH-1:0] div_q,
    output logic             err
);

    localparam int unsigned      CW        = (DIV2 > 1) ? $clog2(DIV2) : 1;
    localparam logic [CW-1:0]    CNT2_LAST = CW'(DIV2 - 1);
    localparam logic [CW-1:0]    CNT2_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] DIV_RST   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic             pend_v;
    logic [CW-1:0]    cnt2;

    logic             wrap;
    logic             wrap2;
    logic             load_ok;
    logic             load_bad;
    logic [WIDTH-1:0] div_m1;

    logic [WIDTH-1:0] cnt_nxt;
    logic [CW-1:0]    cnt2_nxt;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0] pend_nxt;
    logic             pend_v_nxt;
    logic             sq_nxt;

    // div_q is never zero, so div_q-1 cannot underflow.
    always_comb begin
        div_m1   = div_q - ONE;
        wrap     = en && (cnt == div_m1);
        wrap2    = wrap && (cnt2 == CNT2_LAST);
        load_ok  = load && (div_in != '0);
        load_bad = load && (div_in == '0);
    end

    always_comb begin
        cnt_nxt  = cnt;
        cnt2_nxt = cnt2;
        sq_nxt   = sq;
        if (wrap) begin
            cnt_nxt = '0;
            sq_nxt  = ~sq;
            if (cnt2 == CNT2_LAST) begin
                cnt2_nxt = '0;
            end else begin
                cnt2_nxt = cnt2 + CNT2_ONE;
            end
        end else if (en) begin
            cnt_nxt = cnt + ONE;
        end
        // A disabled load restarts the period but keeps cnt2 and sq phase.
        if (load_ok && !en) begin
            cnt_nxt = '0;
        end
    end

    // The running period always finishes on the old divisor; a mid-period
    // load parks in pend and is applied on the next wrap.
    always_comb begin
        div_nxt    = div_q;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        if (load_ok && (!en || wrap)) begin
            div_nxt    = div_in;
            pend_v_nxt = 1'b0;
        end else if (load_ok) begin
            pend_nxt   = div_in;
            pend_v_nxt = 1'b1;
        end else if (wrap && pend_v) begin
            div_nxt    = pend;
            pend_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            cnt2   <= '0;
            div_q  <= DIV_RST;
            pend   <= '0;
            pend_v <= 1'b0;
            tick   <= 1'b0;
            tick2  <= 1'b0;
            sq     <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            cnt2   <= cnt2_nxt;
            div_q  <= div_nxt;
            pend   <= pend_nxt;
            pend_v <= pend_v_nxt;
            tick   <= wrap;
            tick2  <= wrap2;
            sq     <= sq_nxt;
            if (load_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios from the timebase rules
// plus a long randomized run against an event-level reference model.
module tb_tick_gen;

    localparam int DEF_DIV = 100;
    localparam int DIV2    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] div_in = '0;
    logic        tick;
    logic        sq;
    logic        tick2;
    logic [15:0] div_q;
    logic        err;

    int errors = 0;
    int checks = 0;

    tick_gen #(.WIDTH(16), .DEFAULT_DIV(DEF_DIV), .DIV2(DIV2)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .div_in (div_in),
        .tick   (tick),
        .sq     (sq),
        .tick2  (tick2),
        .div_q  (div_q),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs, then sample 1 time unit after that edge.
    task automatic step(input logic e, input logic l, input logic [15:0] d);
        en = e;
        load = l;
        div_in = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 16'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b1, 16'd10);
        step(1'b1, 1'b1, 16'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'd0);
        // Reset with a pending load and a load on the reset edge itself.
        rst = 1'b1;
        step(1'b1, 1'b1, 16'd7);
        rst = 1'b0;
        checks++;
        if ({tick, sq, tick2, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {tick, sq, tick2, err});
        end
        checks++;
        if (div_q !== 16'(DEF_DIV)) begin
            errors++;
            $display("FAIL reset_div_q: got %0d expected %0d", div_q, DEF_DIV);
        end
        // Counter restarts at 0 and the pending divisor is gone.
        for (int k = 1; k <= 200; k++) begin
            step(1'b1, 1'b0, 16'd0);
            checks++;
            if (tick !== (k == 100 || k == 200)) begin
                errors++;
                $display("FAIL reset_restart_tick: edge %0d got %b expected %b", k, tick, (k == 100 || k == 200));
            end
        end
        checks++;
        if (div_q !== 16'(DEF_DIV)) begin
            errors++;
            $display("FAIL reset_pend_cleared: got %0d expected %0d", div_q, DEF_DIV);
        end
    endtask

    task automatic test_defaults();
        int tick_edges[$];
        int tick2_edges[$];
        logic sq99, sq100, sq199, sq200;
        logic tick_at_t2;
        do_reset();
        tick_at_t2 = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            step(1'b1, 1'b0, 16'd0);
            if (tick) tick_edges.push_back(k);
            if (tick2) begin
                tick2_edges.push_back(k);
                tick_at_t2 = tick;
            end
            if (k == 99)  sq99  = sq;
            if (k == 100) sq100 = sq;
            if (k == 199) sq199 = sq;
            if (k == 200) sq200 = sq;
        end
        checks++;
        if (tick_edges.size() != 100) begin
            errors++;
            $display("FAIL defaults_tick_count: got %0d expected 100", tick_edges.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tick_edges[i] != 100 * (i + 1)) begin
                    errors++;
                    $display("FAIL defaults_tick_edge: got %0d expected %0d", tick_edges[i], 100 * (i + 1));
                end
            end
        end
        checks++;
        if ({sq99, sq100, sq199, sq200} !== 4'b0110) begin
            errors++;
            $display("FAIL defaults_sq: got %b expected 0110", {sq99, sq100, sq199, sq200});
        end
        checks++;
        if (tick2_edges.size() != 1 || tick2_edges[0] != 10000 || !tick_at_t2) begin
            errors++;
            $display("FAIL defaults_tick2: got count %0d first %0d expected count 1 at 10000 with tick",
                     tick2_edges.size(), (tick2_edges.size() > 0) ? tick2_edges[0] : -1);
        end
    endtask

    task automatic test_load_midperiod();
        logic exp_tick;
        int exp_div;
        do_reset();
        for (int k = 1; k <= 140; k++) begin
            step(1'b1, (k == 41), 16'd10);
            exp_tick = (k == 100) || (k > 100 && (k - 100) % 10 == 0);
            exp_div  = (k < 100) ? 100 : 10;
            checks++;
            if (tick !== exp_tick || div_q !== 16'(exp_div)) begin
                errors++;
                $display("FAIL midperiod_load: edge %0d got tick=%b div=%0d expected tick=%b div=%0d",
                         k, tick, div_q, exp_tick, exp_div);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        logic exp_tick;
        int exp_div;
        do_reset();
        for (int k = 1; k <= 99; k++) step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b1, 16'd7);
        checks++;
        if (tick !== 1'b1 || div_q !== 16'd7) begin
            errors++;
            $display("FAIL wrap_load: got tick=%b div=%0d expected tick=1 div=7", tick, div_q);
        end
        for (int k = 101; k <= 113; k++) begin
            if (k == 102)      step(1'b1, 1'b1, 16'd5);
            else if (k == 104) step(1'b1, 1'b1, 16'd3);
            else               step(1'b1, 1'b0, 16'd0);
            exp_tick = (k == 107 || k == 110 || k == 113);
            exp_div  = (k < 107) ? 7 : 3;
            checks++;
            if (tick !== exp_tick || div_q !== 16'(exp_div)) begin
                errors++;
                $display("FAIL last_write_wins: edge %0d got tick=%b div=%0d expected tick=%b div=%0d",
                         k, tick, div_q, exp_tick, exp_div);
            end
        end
    endtask

    task automatic test_enable_gap();
        logic sq_hold;
        do_reset();
        for (int k = 1; k <= 50; k++) step(1'b1, 1'b0, 16'd0);
        sq_hold = sq;
        for (int k = 0; k < 25; k++) begin
            step(1'b0, 1'b0, 16'd0);
            checks++;
            if (tick !== 1'b0 || tick2 !== 1'b0 || sq !== sq_hold) begin
                errors++;
                $display("FAIL gap_hold: got tick=%b tick2=%b sq=%b expected 0 0 %b", tick, tick2, sq, sq_hold);
            end
        end
        for (int k = 1; k <= 50; k++) begin
            step(1'b1, 1'b0, 16'd0);
            checks++;
            if (tick !== (k == 50)) begin
                errors++;
                $display("FAIL gap_stretch: enabled edge %0d got %b expected %b", k, tick, (k == 50));
            end
        end
        sq_hold = sq;
        step(1'b0, 1'b1, 16'd4);
        checks++;
        if (div_q !== 16'd4 || sq !== sq_hold || tick !== 1'b0) begin
            errors++;
            $display("FAIL disabled_load: got div=%0d sq=%b tick=%b expected div=4 sq=%b tick=0",
                     div_q, sq, tick, sq_hold);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 16'd0);
            checks++;
            if (tick !== (k == 4 || k == 8)) begin
                errors++;
                $display("FAIL disabled_load_restart: edge %0d got %b expected %b", k, tick, (k == 4 || k == 8));
            end
        end
    endtask

    task automatic test_bad_load();
        logic prev_sq;
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'd0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_initial: got %b expected 0", err);
        end
        step(1'b1, 1'b1, 16'd0);
        checks++;
        if (err !== 1'b1 || div_q !== 16'(DEF_DIV)) begin
            errors++;
            $display("FAIL zero_load: got err=%b div=%0d expected err=1 div=%0d", err, div_q, DEF_DIV);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b1, 16'd1);
        checks++;
        if (err !== 1'b1 || div_q !== 16'd1) begin
            errors++;
            $display("FAIL err_sticky: got err=%b div=%0d expected err=1 div=1", err, div_q);
        end
        for (int k = 0; k < 6; k++) begin
            prev_sq = sq;
            step(1'b1, 1'b0, 16'd0);
            checks++;
            if (tick !== 1'b1 || sq !== ~prev_sq) begin
                errors++;
                $display("FAIL div1: got tick=%b sq=%b expected tick=1 sq=%b", tick, sq, ~prev_sq);
            end
        end
    endtask

    // Reference model tracks enabled cycles into the current period and the
    // total tick count; sq and tick2 follow from that count.
    task automatic test_random();
        int elapsed, period, ticks;
        int pend_q[$];
        logic m_tick, m_tick2, m_err, will_tick;
        logic r, e, l;
        logic [15:0] d;
        do_reset();
        elapsed = 0; period = DEF_DIV; ticks = 0;
        m_tick = 0; m_tick2 = 0; m_err = 0;
        pend_q.delete();
        for (int i = 0; i < 20000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 9) == 0);
            d = 16'($urandom_range(0, 12));
            rst = r;
            step(e, l, d);
            rst = 1'b0;
            if (r) begin
                elapsed = 0; period = DEF_DIV; ticks = 0;
                m_tick = 0; m_tick2 = 0; m_err = 0;
                pend_q.delete();
            end else begin
                will_tick = e && (elapsed + 1 == period);
                m_tick = will_tick;
                m_tick2 = 1'b0;
                if (will_tick) begin
                    ticks++;
                    elapsed = 0;
                    m_tick2 = (ticks % DIV2 == 0);
                end else if (e) begin
                    elapsed++;
                end
                if (l && d == 0) begin
                    m_err = 1'b1;
                    if (will_tick && pend_q.size() > 0) begin
                        period = pend_q[$];
                        pend_q.delete();
                    end
                end else if (l && (!e || will_tick)) begin
                    period = d;
                    elapsed = 0;
                    pend_q.delete();
                end else if (l) begin
                    pend_q.push_back(d);
                end else if (will_tick && pend_q.size() > 0) begin
                    period = pend_q[$];
                    pend_q.delete();
                end
            end
            checks++;
            if (tick !== m_tick || tick2 !== m_tick2 || sq !== ticks[0] ||
                div_q !== 16'(period) || err !== m_err) begin
                errors++;
                $display("FAIL random_cycle %0d: got tick=%b tick2=%b sq=%b div=%0d err=%b expected tick=%b tick2=%b sq=%b div=%0d err=%b",
                         i, tick, tick2, sq, div_q, err, m_tick, m_tick2, ticks[0], period, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_load_midperiod();
        test_load_on_wrap();
        test_enable_gap();
        test_bad_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised tick generator for the oven controller timebase: divides `clk` by a runtime-programmable divisor and emits a one-cycle `tick`, a 50 % duty square wave `sq`, and a cascaded second-stage pulse `tick2` every `DIV2` ticks. It replaces the fixed divide-by-100 pulse divider. It feeds the countdown timer (`tick2`, e.g. 1 Hz) and the display/buzzer logic (`tick`, `sq`). The divisor can be reprogrammed glitch-free while running.

## Interface
Parameters:
- `WIDTH`, 16: width of the divisor and first-stage counter.
- `DEFAULT_DIV`, 100: divisor loaded at reset. Must be 1..2^WIDTH-1.
- `DIV2`, 100: second-stage ratio, in ticks per `tick2`. Must be ≥1.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: count enable.
- `load`, input, 1: one-cycle request to load `div_in`.
- `div_in`, input, WIDTH: new divisor, sampled when `load`=1.
- `tick`, output, 1: one-cycle pulse every `div_q` enabled cycles.
- `sq`, output, 1: toggles on every tick. Period is 2·`div_q`.
- `tick2`, output, 1: one-cycle pulse coincident with every `DIV2`-th tick.
- `div_q`, output, WIDTH: divisor currently in effect.
- `err`, output, 1: sticky flag, set when `load` carries `div_in`=0.

## Operation
- State: `cnt` (WIDTH bits, 0..`div_q`-1), `cnt2` (clog2(DIV2) bits), `div_q`, `pend` (WIDTH bits), `pend_v`, plus the registered outputs.
- Reset (`rst`=1 at an edge): `cnt`=0, `cnt2`=0, `div_q`=`DEFAULT_DIV`, `pend_v`=0, `tick`=0, `tick2`=0, `sq`=0, `err`=0. Reset has priority over everything, including mid-period and with a pending load.
- Wrap condition `wrap` = `en` & (`cnt` == `div_q`-1).
- With `en`=1 and no wrap, `cnt` increments by 1 and `tick` is 0.
- On `wrap`:
  - `cnt` becomes 0 and `tick` becomes 1 on the same edge.
  - `sq` toggles.
  - If `cnt2` == `DIV2`-1: `cnt2` becomes 0 and `tick2` becomes 1. Otherwise `cnt2` increments.
- With `en`=0:
  - `cnt`, `cnt2` and `sq` hold.
  - `tick` and `tick2` are 0 the next cycle.
- Divisor load with `div_in`≠0:
  - If `en`=0: `div_q`←`div_in` immediately, `cnt`←0, `pend_v`←0. `cnt2` and `sq` are unchanged.
  - If `en`=1 and no wrap this edge: `pend`←`div_in`, `pend_v`←1. A newer load overwrites `pend` (last write wins).
  - If `en`=1 and wrap this edge: `div_q`←`div_in` directly, bypassing `pend`, and `pend_v`←0.
  - On a wrap with `pend_v`=1: `div_q`←`pend`, `pend_v`←0.
  - The period in progress always completes with the old divisor.
- Load with `div_in`=0: ignored. `div_q` and `pend` are unchanged and `err`←1. Only reset clears `err`.
- `div_q`=1: the counter is always at `div_q`-1, so `tick`=1 every enabled cycle and `sq` toggles every cycle.
- Widths: comparisons use `div_q`-1 at WIDTH bits. `div_q` is never 0, so there is no underflow. `cnt2` wraps at exactly `DIV2`-1. When `DIV2`=1, `tick2` equals `tick`.

## Timing
- All outputs are registered, with no combinational path from input to output.
- First `tick`: on the `DEFAULT_DIV`-th rising edge after the reset edge, with `en`=1 throughout.
- Steady-state `tick` period is `div_q` enabled cycles, and each pulse is exactly 1 cycle wide.
- `tick2` period is `div_q`·`DIV2` enabled cycles. It is always asserted in the same cycle as a `tick`.
- Load latency:
  - Visible on `div_q` 1 cycle after the load edge when `en`=0 or on a wrap edge.
  - Otherwise visible on the edge of the next wrap.
- Dropping `en` for N cycles stretches the current period by exactly N cycles. Phase is preserved.
- `err` is set on the edge after the bad load.

## Test plan
- Reset, then `en`=1 with defaults 100/100 -> `tick` high on edges 100, 200, 300 after reset; `sq` rises at 100 and falls at 200; `tick2` first high at edge 10000 together with `tick`.
- `en`=1, load `div_in`=10 at `cnt`=40 -> the current period still ends at 100; following ticks every 10 cycles; `div_q` reads 10 from that wrap onward.
- Load `div_in`=7 on the exact wrap edge, then load 5 followed by 3 mid-period -> 7 applies immediately; the next wrap applies 3, never 5.
- `en`=0 for 25 cycles at `cnt`=50 with `div_q`=100 -> the tick is delayed by exactly 25 cycles; during the gap `tick`/`tick2`=0 and `sq` holds. A load of 4 while disabled -> `div_q`=4 and `cnt`=0 the next cycle.
- Load `div_in`=0 -> `div_q` unchanged, `err`=1 and sticky. Load 1 -> `tick` held high every enabled cycle, `sq` toggles every cycle.
- Assert `rst` mid-period with a pending load -> the next cycle has `cnt`=0, `div_q`=100, `pend_v`=0, all outputs 0, `err`=0.
